// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the pending-write scoreboard
// and the register file write port.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned RW   = 5
);
  logic            a_valid;
  logic [RW-1:0]   a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [RW-1:0]   b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            issue_valid;
  logic [RW-1:0]   issue_rd;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            reg_write;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] write_data;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           issue_valid, issue_rd, rs1, rs2,
    input  a_ready, b_ready, rs1_busy, rs2_busy, reg_write, rd, write_data
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
           issue_valid, issue_rd, rs1, rs2,
    output a_ready, b_ready, rs1_busy, rs2_busy, reg_write, rd, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file write port between the WB stage (A) and the
// multi-cycle unit (B), and tracks registers with outstanding B writes.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned NREG         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned RW = $clog2(NREG);
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]   starve_cnt;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic            force_b;
  logic            a_xfer;
  logic            b_xfer;
  logic            win_valid;
  logic [RW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // Per-cycle arbitration; at most one of a_xfer/b_xfer can be true.
  always_comb begin
    force_b     = (starve_cnt == CW'(STARVE_LIMIT));
    bus.b_ready = !reset && (!bus.a_valid || force_b);
    bus.a_ready = !reset && !(force_b && bus.b_valid);
    a_xfer      = bus.a_valid && bus.a_ready;
    b_xfer      = bus.b_valid && bus.b_ready;
    win_valid   = 1'b0;
    win_rd      = bus.a_rd;
    win_data    = bus.a_data;
    if (b_xfer) begin
      win_valid = 1'b1;
      win_rd    = bus.b_rd;
      win_data  = bus.b_data;
    end else if (a_xfer) begin
      win_valid = 1'b1;
    end
  end

  // Scoreboard update: issue set is applied after retire clear so set wins.
  always_comb begin
    pending_nxt = pending;
    if (b_xfer) pending_nxt[bus.b_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign bus.rs1_busy = (bus.rs1 != '0) && pending[bus.rs1];
  assign bus.rs2_busy = (bus.rs2 != '0) && pending[bus.rs2];

  // Registered write port; rd/write_data hold when nothing transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.reg_write  <= 1'b0;
      bus.rd         <= '0;
      bus.write_data <= '0;
    end else begin
      bus.reg_write <= win_valid && (win_rd != '0);
      if (win_valid) begin
        bus.rd         <= win_rd;
        bus.write_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      pending    <= '0;
    end else begin
      pending <= pending_nxt;
      if (b_xfer) begin
        starve_cnt <= '0;
      end else if (bus.b_valid && !bus.b_ready && !force_b) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: driver checks readiness and busy
// flags and queues expected writes; a monitor matches register file writes.
module tb_regfile_wb_arbiter;
  localparam int unsigned XLEN = 64;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    int              cyc;
  } wr_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   cyc;
  wr_t  sb[$];

  regfile_wb_arbiter_if #(.XLEN(XLEN), .RW(5)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every register file write must match the oldest queued write.
  always @(negedge clk) begin
    if (bus.reg_write === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_rd", XLEN'(bus.rd), '1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("write_rd", XLEN'(bus.rd), XLEN'(e.rd));
        chk("write_data", bus.write_data, e.data);
        chk("write_cycle", XLEN'(cyc), XLEN'(e.cyc));
      end
    end
  end

  // One cycle of stimulus with hand-computed ready/busy expectations.
  task automatic step(input logic rst,
                      input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bd,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic ear, input logic ebr, input logic eb1, input logic eb2);
    wr_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.a_valid     = av;
    bus.a_rd        = ard;
    bus.a_data      = ad;
    bus.b_valid     = bv;
    bus.b_rd        = brd;
    bus.b_data      = bd;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.rs1         = r1;
    bus.rs2         = r2;
    @(negedge clk);
    chk("a_ready", XLEN'(bus.a_ready), XLEN'(ear));
    chk("b_ready", XLEN'(bus.b_ready), XLEN'(ebr));
    chk("rs1_busy", XLEN'(bus.rs1_busy), XLEN'(eb1));
    chk("rs2_busy", XLEN'(bus.rs2_busy), XLEN'(eb2));
    if (bv && ebr && brd != 5'd0) begin
      e.rd = brd; e.data = bd; e.cyc = cyc + 1;
      sb.push_back(e);
    end else if (av && ear && !(bv && ebr) && ard != 5'd0) begin
      e.rd = ard; e.data = ad; e.cyc = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic eb1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0, 1, 1, eb1, 0);
  endtask

  initial begin
    logic [4:0]      a_rd_c;
    logic [XLEN-1:0] a_d_c;
    logic [4:0]      b_rd_c;
    logic [XLEN-1:0] b_d_c;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    bus.issue_valid = 0; bus.issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;

    // Reset held two cycles with A waiting, then A writes one cycle later.
    step(1, 1, 5'd1, 64'd11, 0, 0, 0, 0, 0, 5'd1, 5'd2, 0, 0, 0, 0);
    step(1, 1, 5'd1, 64'd11, 0, 0, 0, 0, 0, 5'd1, 5'd2, 0, 0, 0, 0);
    chk("reset_reg_write", XLEN'(bus.reg_write), 64'd0);
    step(0, 1, 5'd1, 64'd11, 0, 0, 0, 0, 0, 5'd1, 5'd2, 1, 0, 0, 0);

    // A only, negative result.
    step(0, 1, 5'd5, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);

    // Contention: A wins four cycles, B forced on the fifth, twice over.
    a_rd_c = 5'd10; a_d_c = 64'h100;
    b_rd_c = 5'd20; b_d_c = 64'hB0B;
    for (int i = 0; i < 10; i++) begin
      logic ear;
      ear = (i % 5) != 4;
      step(0, 1, a_rd_c, a_d_c, 1, b_rd_c, b_d_c, 0, 0, 0, 0, ear, !ear, 0, 0);
      if (ear) begin
        a_rd_c = a_rd_c + 5'd1;
        a_d_c  = a_d_c + 64'h100;
      end else begin
        b_rd_c = b_rd_c + 5'd1;
        b_d_c  = b_d_c + 64'h1000;
      end
    end
    idle(0, 0);

    // Scoreboard: issue x9, B returns six cycles later.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) idle(5'd9, 1);
    step(0, 0, 0, 0, 1, 5'd9, 64'h99, 0, 0, 5'd9, 5'd9, 1, 1, 1, 1);
    idle(5'd9, 0);

    // Set/clear collision on x3: set wins.
    step(0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd3, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 5'd3, 64'h33, 1, 5'd3, 5'd3, 5'd3, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 5'd3, 64'h34, 0, 0, 5'd3, 5'd3, 1, 1, 1, 1);
    idle(5'd3, 0);

    // x0 from B: accepted, no write, x0 never busy.
    step(0, 0, 0, 0, 1, 5'd0, 64'd123, 1, 5'd0, 0, 0, 1, 1, 0, 0);
    idle(0, 0);
    chk("x0_rd_hold_free_write", XLEN'(bus.reg_write), 64'd0);

    // Reset mid-operation drops the in-flight A result.
    step(1, 1, 5'd7, 64'd77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    // Back-to-back A writes, one per cycle.
    step(0, 1, 5'd11, 64'hA1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 5'd12, 64'hA2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 1, 5'd13, 64'hA3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) idle(0, 0);

    chk("queue_drained", XLEN'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
